// File: rtl/wave_sequencer_if.sv
// Control, configuration and wave-ROM address bundle for wave_sequencer.
// The master drives requests and playlist writes; the slave drives the ROM address and status.
interface wave_sequencer_if #(
    parameter int DIV_W = 12,
    parameter int CYC_W = 8
);
    logic                      start;
    logic                      stop;
    logic                      loop_mode;
    logic                      cfg_we;
    logic [1:0]                cfg_addr;
    logic [2+DIV_W+CYC_W-1:0]  cfg_data;
    logic [3:0]                sig_addr;
    logic [1:0]                wave_sel;
    logic                      sample_stb;
    logic [1:0]                entry_idx;
    logic                      busy;
    logic                      done;

    modport master (
        output start, stop, loop_mode, cfg_we, cfg_addr, cfg_data,
        input  sig_addr, wave_sel, sample_stb, entry_idx, busy, done
    );

    modport slave (
        input  start, stop, loop_mode, cfg_we, cfg_addr, cfg_data,
        output sig_addr, wave_sel, sample_stb, entry_idx, busy, done
    );
endinterface

// File: rtl/wave_sequencer.sv
// 4-entry playlist sequencer stepping a 16-sample wave ROM address at a per-entry rate.
// Optional macro WAVE_SEQ_LOOP_EN: loop_mode replays the playlist instead of finishing.
module wave_sequencer #(
    parameter int DIV_W = 12,
    parameter int CYC_W = 8
) (
    input  logic            clk_50,
    input  logic            rst_key0,
    wave_sequencer_if.slave bus
);
    localparam int EW = 2 + DIV_W + CYC_W;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [EW-1:0]    r_tab [4];
    logic [1:0]       r_idx;
    logic [1:0]       r_wsel;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_dcnt;
    logic [CYC_W-1:0] r_cyc;
    logic [CYC_W-1:0] r_pcnt;
    logic [3:0]       r_addr;
    logic             r_busy;
    logic             r_done;

    logic [DIV_W-1:0] w_div_m1;
    logic             w_tick;
    logic             w_wrap_end;
    logic             w_adv;
    logic             w_abort;
    logic             w_loop;
    logic             w_last;
    logic [1:0]       w_nidx;
    logic [EW-1:0]    w_nent;

    // div=0 ticks every cycle, same as div=1
    assign w_div_m1   = (r_div == '0) ? '0 : r_div - DIV_W'(1);
    assign w_tick     = (r_state == S_RUN) && (r_dcnt == w_div_m1);
    assign w_wrap_end = w_tick && (r_addr == 4'hF) && (r_pcnt == r_cyc - CYC_W'(1));
    assign w_abort    = bus.stop && ((r_state == S_LOAD) || (r_state == S_RUN));
    assign w_adv      = ((r_state == S_LOAD) && (r_cyc == '0)) || w_wrap_end;
    assign w_nidx     = r_idx + 2'd1;
    assign w_nent     = r_tab[w_nidx];

`ifdef WAVE_SEQ_LOOP_EN
    assign w_loop = bus.loop_mode;
`else
    logic w_unused_loop;
    assign w_loop        = 1'b0;
    assign w_unused_loop = bus.loop_mode;
`endif

    assign w_last = (r_idx == 2'd3) && !w_loop;

    always_ff @(posedge clk_50) begin
        if (rst_key0) begin
            r_state <= S_IDLE;
            for (int i = 0; i < 4; i++) r_tab[i] <= '0;
            r_idx   <= '0;
            r_wsel  <= '0;
            r_div   <= '0;
            r_dcnt  <= '0;
            r_cyc   <= '0;
            r_pcnt  <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.cfg_we && (r_state == S_IDLE))
                r_tab[bus.cfg_addr] <= bus.cfg_data;

            if (w_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_addr  <= '0;
                r_dcnt  <= '0;
                r_pcnt  <= '0;
            end else if (w_adv) begin
                // Entry finished or skipped: next entry, or finish the playlist
                if (w_last) begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= S_LOAD;
                    r_idx   <= w_nidx;
                    {r_wsel, r_div, r_cyc} <= w_nent;
                    r_dcnt  <= '0;
                    r_pcnt  <= '0;
                    r_addr  <= '0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            r_state <= S_LOAD;
                            r_busy  <= 1'b1;
                            r_idx   <= '0;
                            {r_wsel, r_div, r_cyc} <= r_tab[0];
                            r_dcnt  <= '0;
                            r_pcnt  <= '0;
                            r_addr  <= '0;
                        end
                    end
                    S_LOAD: r_state <= S_RUN;
                    S_RUN: begin
                        if (w_tick) begin
                            r_dcnt <= '0;
                            r_addr <= r_addr + 4'd1;
                            if (r_addr == 4'hF) r_pcnt <= r_pcnt + CYC_W'(1);
                        end else begin
                            r_dcnt <= r_dcnt + DIV_W'(1);
                        end
                    end
                    S_DONE: r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.sig_addr   = r_addr;
    assign bus.wave_sel   = r_wsel;
    assign bus.sample_stb = w_tick && !bus.stop;
    assign bus.entry_idx  = r_idx;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer: playback timing, skip entries, stop, config lockout, loop, reset.
module tb_wave_sequencer;
    localparam int DIV_W = 12;
    localparam int CYC_W = 8;

    logic clk_50 = 1'b0;
    logic rst_key0;
    always #5 clk_50 = ~clk_50;

    wave_sequencer_if #(.DIV_W(DIV_W), .CYC_W(CYC_W)) bus ();

    wave_sequencer #(.DIV_W(DIV_W), .CYC_W(CYC_W)) dut (
        .clk_50   (clk_50),
        .rst_key0 (rst_key0),
        .bus      (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int stb_cyc[$];
    int stb_idx[$];
    int stb_ws[$];
    logic [2+DIV_W+CYC_W-1:0] wr_word;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic cfg(input int a, input int ws, input int dv, input int cy);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'(a);
        bus.cfg_data = {2'(ws), DIV_W'(dv), CYC_W'(cy)};
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    // After return the bench sits in the first LOAD cycle (cycle 0)
    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Observe from cycle 0 until done; optional loop_mode drop and playlist write at given cycles
    task automatic run_mon(input int max, input int drop_at, input int wr_at, output int done_c);
        stb_cyc.delete(); stb_idx.delete(); stb_ws.delete();
        done_c = -1;
        for (int c = 0; c < max; c++) begin
            if (c == drop_at) bus.loop_mode = 1'b0;
            if (c == wr_at) begin
                bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = wr_word;
            end
            if (c == wr_at + 1) bus.cfg_we = 1'b0;
            if (bus.sample_stb) begin
                stb_cyc.push_back(c);
                stb_idx.push_back(int'(bus.entry_idx));
                stb_ws.push_back(int'(bus.wave_sel));
            end
            if (bus.done) begin
                done_c = c;
                break;
            end
            tick();
        end
        bus.cfg_we = 1'b0;
    endtask

    task automatic chk_stb(input string tag, input int idx, input int n_exp,
                           input int first_exp, input int gap_exp, input int ws_exp);
        int n, first, prev, badgap, badws;
        n = 0; first = -1; prev = -1; badgap = 0; badws = 0;
        foreach (stb_cyc[k]) begin
            if (stb_idx[k] == idx) begin
                if (n == 0) first = stb_cyc[k];
                else if (gap_exp != 0 && stb_cyc[k] - prev != gap_exp) badgap++;
                if (stb_ws[k] != ws_exp) badws++;
                prev = stb_cyc[k];
                n++;
            end
        end
        chk({tag, "_count"}, n, n_exp);
        chk({tag, "_first"}, first, first_exp);
        chk({tag, "_gaps"}, badgap, 0);
        chk({tag, "_wsel"}, badws, 0);
    endtask

    initial begin
        int dc;
        int seen;
        rst_key0 = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop_mode = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        wr_word = '0;
        tick(); tick();
        chk("rst_addr", int'(bus.sig_addr), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_idx",  int'(bus.entry_idx), 0);
        rst_key0 = 1'b0;

        // Single entry, div=3: 16 strobes every 3 cycles, then three skip LOADs, then DONE
        cfg(0, 2, 3, 1);
        pulse_start();
        chk("t1_busy_load", int'(bus.busy), 1);
        chk("t1_wsel_load", int'(bus.wave_sel), 2);
        run_mon(300, -1, -1, dc);
        chk_stb("t1", 0, 16, 3, 3, 2);
        chk("t1_done_cyc", dc, 52);
        chk("t1_busy_done", int'(bus.busy), 0);
        chk("t1_addr_done", int'(bus.sig_addr), 0);
        tick();
        chk("t1_done_pulse", int'(bus.done), 0);
        chk("t1_busy_idle", int'(bus.busy), 0);

        // div=0 back-to-back for 2 periods, then entry1 at div=2
        cfg(0, 3, 0, 2);
        cfg(1, 1, 2, 1);
        pulse_start();
        run_mon(300, -1, -1, dc);
        chk_stb("t2e0", 0, 32, 1, 1, 3);
        chk_stb("t2e1", 1, 16, 35, 2, 1);
        chk("t2_done_cyc", dc, 68);
        tick();

        // stop on the 5th tick
        cfg(0, 0, 2, 1);
        cfg(1, 0, 0, 0);
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        chk("t3_stb5", int'(bus.sample_stb), 1);
        chk("t3_addr5", int'(bus.sig_addr), 4);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("t3_busy", int'(bus.busy), 0);
        chk("t3_addr", int'(bus.sig_addr), 0);
        seen = int'(bus.done);
        for (int i = 0; i < 4; i++) begin
            tick();
            seen += int'(bus.done) + int'(bus.busy);
        end
        chk("t3_no_done", seen, 0);

        // write during RUN is dropped, the same write in IDLE takes effect
        wr_word = {2'd3, DIV_W'(1), CYC_W'(1)};
        pulse_start();
        run_mon(300, -1, 5, dc);
        chk_stb("t4run", 0, 16, 2, 2, 0);
        chk("t4run_done", dc, 36);
        tick();
        cfg(0, 3, 1, 1);
        pulse_start();
        chk("t4_wsel_load", int'(bus.wave_sel), 3);
        run_mon(300, -1, -1, dc);
        chk_stb("t4idle", 0, 16, 1, 1, 3);
        chk("t4idle_done", dc, 20);
        tick();

        // loop_mode with a single-entry playlist
        cfg(0, 1, 0, 1);
        bus.loop_mode = 1'b1;
        pulse_start();
        run_mon(400, 60, -1, dc);
`ifdef WAVE_SEQ_LOOP_EN
        chk_stb("t5", 0, 64, 1, 0, 1);
        chk("t5_done_cyc", dc, 80);
`else
        chk_stb("t5", 0, 16, 1, 1, 1);
        chk("t5_done_cyc", dc, 20);
`endif
        bus.loop_mode = 1'b0;
        tick();

        // reset mid-RUN, then all-skip playlist
        cfg(0, 2, 3, 1);
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        rst_key0 = 1'b1;
        tick();
        rst_key0 = 1'b0;
        chk("t6_addr", int'(bus.sig_addr), 0);
        chk("t6_wsel", int'(bus.wave_sel), 0);
        chk("t6_idx",  int'(bus.entry_idx), 0);
        chk("t6_stb",  int'(bus.sample_stb), 0);
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_done", int'(bus.done), 0);
        pulse_start();
        run_mon(50, -1, -1, dc);
        chk("t6_nstb", stb_cyc.size(), 0);
        chk("t6_done_cyc", dc, 4);
        tick();

        // start together with stop stays idle
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("t7_busy", int'(bus.busy), 0);
        tick();
        chk("t7_busy2", int'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
